// File: rtl/sar_adc_ctrl.sv
// ---------------------------------------------------------------------------
// sar_adc_ctrl
// Successive-approximation control FSM for an 8-bit SAR ADC. It drives the
// track/hold switch and the DAC trial code, samples the analog comparator
// once per bit, and registers the final code with a one-cycle done pulse.
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_start      conversion request, level-sampled in IDLE or DONE only
//   i_comp_in    comparator output, 1 when Vin >= Vdac(o_dac_code)
//   o_sample     track/hold control, 1 = track
//   o_dac_code   current trial code to the DAC
//   o_busy       high while sampling or trialling bits
//   o_result     last completed conversion code
//   o_done       one-cycle pulse, o_result valid in the same cycle
// ---------------------------------------------------------------------------
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_comp_in,
    output logic             o_sample,
    output logic [WIDTH-1:0] o_dac_code,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_result,
    output logic             o_done
);

    localparam int CNT_W = 8;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_TRIAL,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [BIT_W-1:0] r_bit;

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_kept;

    // The bit currently under trial, and the trial code after the comparator
    // has decided whether that bit stays set.
    assign w_mask = WIDTH'(1) << r_bit;
    assign w_kept = i_comp_in ? o_dac_code : (o_dac_code & ~w_mask);

    // Single registered FSM; every output is a register so nothing from the
    // inputs reaches the outputs combinationally. o_done defaults low so it
    // only ever pulses for the one cycle spent in DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            o_sample   <= 1'b0;
            o_dac_code <= '0;
            o_busy     <= 1'b0;
            o_result   <= '0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state  <= ST_SAMPLE;
                        r_cnt    <= CNT_W'(SAMPLE_CYCLES - 1);
                        o_sample <= 1'b1;
                        o_busy   <= 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_TRIAL;
                        r_bit      <= BIT_W'(WIDTH - 1);
                        r_cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                        o_sample   <= 1'b0;
                        o_dac_code <= WIDTH'(1) << (WIDTH - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_TRIAL: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_bit != '0) begin
                        // Bit decided; move on and set the next lower bit as
                        // the new trial.
                        r_bit      <= r_bit - 1'b1;
                        r_cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                        o_dac_code <= w_kept | (w_mask >> 1);
                    end else begin
                        r_state    <= ST_DONE;
                        o_dac_code <= w_kept;
                        o_result   <= w_kept;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                    end
                end

                ST_DONE: begin
                    // A held start chains straight into the next sample
                    // phase without passing through IDLE.
                    o_dac_code <= '0;
                    if (i_start) begin
                        r_state  <= ST_SAMPLE;
                        r_cnt    <= CNT_W'(SAMPLE_CYCLES - 1);
                        o_sample <= 1'b1;
                        o_busy   <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    o_sample   <= 1'b0;
                    o_busy     <= 1'b0;
                    o_dac_code <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_adc_ctrl
// Scoreboard bench for sar_adc_ctrl. Two instances: dutA with default timing
// and dutB with single-cycle sample/settle. Each start pushes the expected
// code and expected done cycle; monitors pop and compare on every done pulse.
// "Start edge" is the clock edge after which start is raised; start is then
// sampled by the DUT one edge later.
// ---------------------------------------------------------------------------
module tb_sar_adc_ctrl;

    typedef struct {
        logic [7:0] code;
        int         cycle;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       startA, startB;
    logic [7:0] vinA, vinB;
    logic       compA, compB;
    logic       sampleA, sampleB, busyA, busyB, doneA, doneB;
    logic [7:0] dacA, dacB, resultA, resultB;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qA[$];
    exp_t qB[$];
    exp_t expA, expB;
    int   sampRunA = 0;
    int   doneRunA = 0;

    always #5 clk = ~clk;

    // Cycle counter; after posedge e (plus a small delay) it reads e.
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal comparator model for each instance.
    assign compA = (vinA >= dacA);
    assign compB = (vinB >= dacB);

    sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)) dutA (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (startA),
        .i_comp_in  (compA),
        .o_sample   (sampleA),
        .o_dac_code (dacA),
        .o_busy     (busyA),
        .o_result   (resultA),
        .o_done     (doneA)
    );

    sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(1)) dutB (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (startB),
        .i_comp_in  (compB),
        .o_sample   (sampleB),
        .o_dac_code (dacB),
        .o_busy     (busyB),
        .o_result   (resultB),
        .o_done     (doneB)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single start pulse on dutA with its expected completion queued.
    task automatic applyStimulus(input logic [7:0] vin);
        vinA   = vin;
        startA = 1'b1;
        qA.push_back('{vin, cyc + 21});
        tick(1);
        startA = 1'b0;
    endtask

    task automatic waitIdleA();
        int n = 0;
        while (qA.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        if (qA.size() != 0) begin
            checkOutput("timeoutA", qA.size(), 0);
            qA.delete();
        end
        tick(2);
    endtask

    // Monitor for dutA: result/latency on done, plus sample-phase width and
    // done pulse width whenever those signals fall.
    always @(negedge clk) begin
        if (doneA === 1'b1) begin
            if (qA.size() == 0) begin
                checkOutput("spuriousDoneA", 1, 0);
            end else begin
                expA = qA.pop_front();
                checkOutput("resultA", resultA, expA.code);
                checkOutput("doneCycleA", cyc, expA.cycle);
                checkOutput("busyInDoneA", busyA, 0);
                checkOutput("sampleInDoneA", sampleA, 0);
                checkOutput("dacInDoneA", dacA, expA.code);
            end
        end
        if (sampleA === 1'b1) begin
            sampRunA++;
        end else if (sampRunA != 0) begin
            checkOutput("sampleWidthA", sampRunA, 4);
            sampRunA = 0;
        end
        if (doneA === 1'b1) begin
            doneRunA++;
        end else if (doneRunA != 0) begin
            checkOutput("doneWidthA", doneRunA, 1);
            doneRunA = 0;
        end
    end

    // Monitor for dutB.
    always @(negedge clk) begin
        if (doneB === 1'b1) begin
            if (qB.size() == 0) begin
                checkOutput("spuriousDoneB", 1, 0);
            end else begin
                expB = qB.pop_front();
                checkOutput("resultB", resultB, expB.code);
                checkOutput("doneCycleB", cyc, expB.cycle);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] seq [8];
        int e;
        int n;
        seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        rst = 1'b1; startA = 1'b0; startB = 1'b0; vinA = 8'h00; vinB = 8'h00;
        tick(3);
        @(negedge clk);
        checkOutput("rstSample", sampleA, 0);
        checkOutput("rstBusy", busyA, 0);
        checkOutput("rstDac", dacA, 0);
        checkOutput("rstResult", resultA, 0);
        checkOutput("rstDone", doneA, 0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // VIN=A5: full DAC trial sequence, each code held two cycles.
        $display("[TB] conversion VIN=A5");
        e = cyc;
        applyStimulus(8'hA5);
        tick(4);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            checkOutput("dacSeq", dacA, {24'd0, seq[j/2]});
            checkOutput("busyTrial", busyA, 1);
        end
        waitIdleA();

        $display("[TB] boundary codes");
        applyStimulus(8'h00);
        waitIdleA();
        applyStimulus(8'hFF);
        waitIdleA();

        // Held start: back-to-back conversions, VIN switched in second SAMPLE.
        $display("[TB] back-to-back conversions");
        e = cyc;
        vinA   = 8'h3C;
        startA = 1'b1;
        qA.push_back('{8'h3C, e + 21});
        qA.push_back('{8'hC3, e + 42});
        tick(22);
        @(negedge clk);
        checkOutput("busyBackToBack", busyA, 1);
        checkOutput("sampleBackToBack", sampleA, 1);
        tick(1);
        vinA = 8'hC3;
        tick(7);
        startA = 1'b0;
        waitIdleA();

        // Start pulses during TRIAL must be ignored.
        $display("[TB] start ignored while busy");
        applyStimulus(8'h5A);
        tick(5);
        for (int k = 0; k < 3; k++) begin
            startA = 1'b1;
            tick(1);
            startA = 1'b0;
            tick(3);
        end
        waitIdleA();
        tick(25);

        // Reset during the bit-4 trial aborts with no done pulse.
        $display("[TB] reset mid-conversion");
        applyStimulus(8'h77);
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        qA.delete();
        @(negedge clk);
        checkOutput("abortSample", sampleA, 0);
        checkOutput("abortBusy", busyA, 0);
        checkOutput("abortDac", dacA, 0);
        checkOutput("abortResult", resultA, 0);
        checkOutput("abortDone", doneA, 0);
        tick(30);
        applyStimulus(8'h77);
        waitIdleA();

        // Minimal timing instance.
        $display("[TB] single-cycle sample/settle");
        e = cyc;
        vinB   = 8'h81;
        startB = 1'b1;
        qB.push_back('{8'h81, e + 10});
        tick(1);
        startB = 1'b0;
        n = 0;
        while (qB.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        if (qB.size() != 0) begin
            checkOutput("timeoutB", qB.size(), 0);
            qB.delete();
        end
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
